// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder sequencer.
package serial_adder_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;

endpackage

// File: rtl/fulladder.sv
// Single-bit full-adder cell, time-shared by serial_adder_ctrl.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell stepped LSB first, with
// valid/ready handshakes on operand capture and result delivery.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  sa_state_t        state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic             msb_cin_q, msb_cin_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic             fa_s, fa_cout;

  fulladder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    sum_sh_d  = sum_sh_q;
    carry_d   = carry_q;
    msb_cin_d = msb_cin_q;
    bit_cnt_d = bit_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d    = a;
          b_sh_d    = b;
          carry_d   = cin;
          bit_cnt_d = '0;
          sum_sh_d  = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        // Counter saturates at the last bit so it never wraps.
        if (bit_cnt_q == LastBit) begin
          msb_cin_d = carry_q;
          state_d   = DONE;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over both handshakes.
    if (clear) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      sum_sh_q  <= '0;
      carry_q   <= 1'b0;
      msb_cin_q <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      sum_sh_q  <= sum_sh_d;
      carry_q   <= carry_d;
      msb_cin_q <= msb_cin_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_sh_q;
  assign cout      = carry_q;
  assign overflow  = msb_cin_q ^ carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed vectors plus a random
// regression scored against an arithmetic reference model.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         clear;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int errors;
  int checks;
  int done_cnt;
  // Cycles since accept: -1 idle, 0..W-1 adding, W result pending.
  int phase;
  logic [W-1:0] m_sum;
  logic         m_cout;
  logic         m_ovf;

  serial_adder_ctrl #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    logic [W:0] full;
    if (reset || clear) begin
      phase = -1;
    end else if (phase == -1) begin
      if (in_valid) begin
        full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        m_sum  = full[W-1:0];
        m_cout = full[W];
        m_ovf  = (a[W-1] == b[W-1]) && (m_sum[W-1] != a[W-1]);
        phase  = 0;
      end
    end else if (phase < W) begin
      phase++;
    end else if (out_ready) begin
      phase = -1;
      done_cnt++;
    end
  endtask

  // One clock: compare at negedge, advance model at posedge, return at posedge+1.
  task automatic step();
    @(negedge clk);
    if (!reset) begin
      chk("in_ready", 32'(in_ready), 32'(phase == -1));
      chk("out_valid", 32'(out_valid), 32'(phase == W));
      if (phase == W) begin
        chk("sum", 32'(sum), 32'(m_sum));
        chk("cout", 32'(cout), 32'(m_cout));
        chk("overflow", 32'(overflow), 32'(m_ovf));
      end
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic wait_valid(input string tag, output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    chk({tag, "_reached_done"}, 32'(out_valid), 32'd1);
  endtask

  task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                         input logic [W-1:0] es, input logic ec, input logic eo,
                         input string tag);
    int lat;
    a = ta; b = tb; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    wait_valid(tag, lat);
    chk({tag, "_latency"}, 32'(lat), 32'(W));
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
    chk({tag, "_model_sum"}, 32'(m_sum), 32'(es));
    chk({tag, "_model_ovf"}, 32'(m_ovf), 32'(eo));
    step();
    chk({tag, "_idle_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int cyc;
    errors = 0; checks = 0; done_cnt = 0; phase = -1;
    m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    clear = 1'b0; out_ready = 1'b0;

    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_txn(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, 1'b0, "v3c42");
    run_txn(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "vff01");
    run_txn(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "v7f01");
    run_txn(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1, "v8080c");

    // Back-pressure, with fresh operands offered throughout RUN/DONE.
    a = 8'h12; b = 8'h34; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    step();
    a = 8'hAA; b = 8'h55; cin = 1'b0;
    for (int i = 0; i < W; i++) begin
      chk("bp_in_ready_run", 32'(in_ready), 32'd0);
      step();
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_sum", 32'(sum), 32'h47);
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_idle", 32'(in_ready), 32'd1);
    step();
    chk("bp_next_accepted", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    wait_valid("bp_next", lat);
    chk("bp_next_sum", 32'(sum), 32'hFF);
    step();

    // Asynchronous reset mid-RUN (bit_cnt=3).
    a = 8'h55; b = 8'h0F; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    #2;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_sum", 32'(sum), 32'd0);
    chk("arst_cout", 32'(cout), 32'd0);
    phase = -1;
    step();
    reset = 1'b0;
    run_txn(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, "post_rst");

    // clear during RUN: no result pulse afterwards.
    a = 8'h21; b = 8'h43; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (2) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_run_idle", 32'(in_ready), 32'd1);
    repeat (W + 2) step();

    // clear in DONE together with out_ready.
    a = 8'h10; b = 8'h20; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    wait_valid("clr_done", lat);
    out_ready = 1'b1; clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_done_idle", 32'(in_ready), 32'd1);
    chk("clr_done_no_valid", 32'(out_valid), 32'd0);

    // clear beats in_valid in IDLE.
    in_valid = 1'b1; clear = 1'b1;
    step();
    in_valid = 1'b0; clear = 1'b0;
    chk("clr_idle_not_accepted", 32'(in_ready), 32'd1);
    repeat (W + 2) step();

    // Random regression.
    done_cnt = 0;
    cyc = 0;
    while (done_cnt < 1000 && cyc < 40000) begin
      a = W'($urandom());
      b = W'($urandom());
      cin = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 99) == 0);
      step();
      cyc++;
    end
    chk("random_completed", 32'(done_cnt), 32'd1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
